// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolve path.
//   seg_width()    : bits resolved per pipeline segment for a given width/depth
//   CARRY_SHIFT    : weight offset of the carry vector relative to the sum vector
//   stage_state_t  : register image of one segment at the default configuration
package csa_pkg;

    localparam int CARRY_SHIFT = 1;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // The resolved result is WIDTH+2 bits: one extra for the carry shift and
    // one for the final carry-out of the addition.
    function automatic int seg_width(input int width, input int stages);
        return (width + 2) / stages;
    endfunction

    localparam int DEF_W2    = DEF_WIDTH + 2;
    localparam int DEF_SEG_W = seg_width(DEF_WIDTH, DEF_STAGES);

    // One segment's registers: valid bit, result resolved so far, carry into
    // the next segment, and the operands skewed along with the entry.
    typedef struct packed {
        logic                            vld;
        logic [DEF_W2-1:0]               res;
        logic                            cy;
        logic [DEF_W2-1:0]               a;
        logic [DEF_W2-1:0]               b;
    } stage_state_t;

endpackage

// File: rtl/csa_resolve_stage.sv
// One carry-propagate segment: adds bits [IDX*SEG_W +: SEG_W] of the two
// operands plus the incoming carry, merges the segment into the partial
// result, and registers everything for the next segment.
//   clk, rst          : clock, synchronous active-high reset
//   advance           : global pipeline enable
//   vld_i/res_i/cy_i  : entry from the previous segment (or the block input)
//   a_i/b_i           : full-width operands travelling with the entry
//   vld_o/res_o/cy_o  : registered entry for the next segment
//   a_o/b_o           : registered operands for the next segment
module csa_resolve_stage
    import csa_pkg::*;
#(
    parameter int W2    = DEF_W2,
    parameter int SEG_W = DEF_SEG_W,
    parameter int IDX   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          vld_i,
    input  logic [W2-1:0] res_i,
    input  logic          cy_i,
    input  logic [W2-1:0] a_i,
    input  logic [W2-1:0] b_i,
    output logic          vld_o,
    output logic [W2-1:0] res_o,
    output logic          cy_o,
    output logic [W2-1:0] a_o,
    output logic [W2-1:0] b_o
);

    localparam int LO = IDX * SEG_W;

    typedef struct packed {
        logic          vld;
        logic [W2-1:0] res;
        logic          cy;
        logic [W2-1:0] a;
        logic [W2-1:0] b;
    } state_t;

    state_t          q, d;
    logic [SEG_W:0]  seg_sum;

    assign seg_sum = {1'b0, a_i[LO +: SEG_W]}
                   + {1'b0, b_i[LO +: SEG_W]}
                   + {{SEG_W{1'b0}}, cy_i};

    // Data only loads for valid entries so a bubble never disturbs the
    // output value (out_result stays 0 after reset until a real result).
    // Bits of res_i at and above this segment are still zero, so OR-ing the
    // segment in is the same as overwriting it.
    always_comb begin
        d     = q;
        d.vld = vld_i;
        if (vld_i) begin
            d.res = res_i | (W2'(seg_sum[SEG_W-1:0]) << LO);
            d.cy  = seg_sum[SEG_W];
            d.a   = a_i;
            d.b   = b_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (advance) begin
            q <= d;
        end
    end

    assign vld_o = q.vld;
    assign res_o = q.res;
    assign cy_o  = q.cy;
    assign a_o   = q.a;
    assign b_o   = q.b;

endmodule

// File: rtl/csa_resolver.sv
// Pipelined carry-propagate stage turning a carry-save pair back into binary:
// out_result = in_sum + 2*in_carry, WIDTH+2 bits, never overflows.
// The carry chain is cut into STAGES registered segments with a single global
// enable, so latency is exactly STAGES cycles and throughput one per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake (in_ready = pipeline advances)
//   in_sum, in_carry     : carry-save vectors, carry has weight 2^(i+1)
//   out_valid/out_ready  : output handshake
//   out_result           : resolved binary value
//   busy                 : some segment holds a valid entry
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_result,
    output logic             busy
);

    localparam int W2    = WIDTH + 2;
    localparam int SEG_W = seg_width(WIDTH, STAGES);

    generate
        if (STAGES < 1 || (W2 % STAGES) != 0) begin : g_bad_cfg
            $error("csa_resolver: WIDTH+2 (%0d) must be divisible by STAGES (%0d)", W2, STAGES);
        end
    endgenerate

    // Index 0 is the block input; index k+1 is the output of segment k.
    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0][W2-1:0]  res_pipe;
    logic [STAGES:0]          cy_pipe;
    logic [STAGES:0][W2-1:0]  a_pipe;
    logic [STAGES:0][W2-1:0]  b_pipe;
    logic                     advance;

    assign advance  = !vld_pipe[STAGES] || out_ready;
    assign in_ready = advance;

    assign vld_pipe[0] = in_valid;
    assign res_pipe[0] = '0;
    assign cy_pipe[0]  = 1'b0;
    assign a_pipe[0]   = W2'(in_sum);
    assign b_pipe[0]   = W2'(in_carry) << CARRY_SHIFT;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            csa_resolve_stage #(
                .W2    (W2),
                .SEG_W (SEG_W),
                .IDX   (k)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .advance (advance),
                .vld_i   (vld_pipe[k]),
                .res_i   (res_pipe[k]),
                .cy_i    (cy_pipe[k]),
                .a_i     (a_pipe[k]),
                .b_i     (b_pipe[k]),
                .vld_o   (vld_pipe[k+1]),
                .res_o   (res_pipe[k+1]),
                .cy_o    (cy_pipe[k+1]),
                .a_o     (a_pipe[k+1]),
                .b_o     (b_pipe[k+1])
            );
        end
    endgenerate

    assign out_valid  = vld_pipe[STAGES];
    assign out_result = res_pipe[STAGES];
    assign busy       = |vld_pipe[STAGES:1];

    // Final operands are fully consumed and the top carry-out is always 0
    // (the result width already covers the maximum sum).
    logic unused_tail;
    assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES], cy_pipe[STAGES]};

endmodule

// File: tb/tb_csa_resolver.sv
module tb_csa_resolver;

    localparam int WA = 8;
    localparam int SA = 2;
    localparam int WB = 30;
    localparam int SB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=8, STAGES=2
    logic            rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [WA-1:0]   in_sum_a, in_carry_a;
    logic [WA+1:0]   out_result_a;
    // DUT B: WIDTH=30, STAGES=4
    logic            rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [WB-1:0]   in_sum_b, in_carry_b;
    logic [WB+1:0]   out_result_b;

    csa_resolver #(.WIDTH(WA), .STAGES(SA)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_sum(in_sum_a), .in_carry(in_carry_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_result(out_result_a), .busy(busy_a));

    csa_resolver #(.WIDTH(WB), .STAGES(SB)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_sum(in_sum_b), .in_carry(in_carry_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_result(out_result_b), .busy(busy_b));

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_a[$];
    longint exp_b[$];

    // Reference: the value a carry-save pair represents.
    function automatic longint model(input longint s, input longint c);
        return s + 2 * c;
    endfunction

    task automatic check(input string name, input longint got, input longint req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Monitors: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst_a && out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_output got=%0h required=none", out_result_a);
            end else begin
                check("a_result", longint'(out_result_a), exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_output got=%0h required=none", out_result_b);
            end else begin
                check("b_result", longint'(out_result_b), exp_b.pop_front());
            end
        end
    end

    // Present a pair on A and hold it until accepted.
    task automatic send_a(input logic [WA-1:0] s, input logic [WA-1:0] c);
        int  n = 0;
        bit  done = 0;
        in_valid_a = 1'b1; in_sum_a = s; in_carry_a = c;
        while (!done) begin
            @(negedge clk);
            if (in_ready_a) begin
                exp_a.push_back(model(longint'(s), longint'(c)));
                done = 1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n > 100) begin
                n_tests++; n_fail++;
                $display("FAIL a_send_timeout got=no_accept required=accept");
                done = 1;
            end
        end
        in_valid_a = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        while (exp_a.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("a_drain_left", exp_a.size(), 0);
        @(negedge clk);
        check("a_drain_busy", busy_a, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_a();
        logic [WA+1:0] held;
        // reset state
        rst_a = 1'b1; in_valid_a = 1'b0; in_sum_a = '0; in_carry_a = '0; out_ready_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        check("a_rst_out_valid", out_valid_a, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_out_result", out_result_a, 0);
        check("a_rst_in_ready", in_ready_a, 1);
        @(posedge clk); #1;

        // latency: exactly SA cycles from handshake to out_valid
        send_a(8'h0F, 8'h01);
        for (int i = 0; i < SA - 1; i++) begin
            @(negedge clk);
            check("a_lat_early", out_valid_a, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("a_lat_valid", out_valid_a, 1);
        @(posedge clk); #1;
        drain_a();

        // max value, segment carry crossing, zero
        send_a(8'hFF, 8'hFF);
        send_a(8'h1F, 8'h01);
        send_a(8'h00, 8'h00);
        send_a(8'h80, 8'h80);
        drain_a();

        // backpressure: 4 back-to-back pairs, 3-cycle stall on first result
        fork
            begin
                send_a(8'h11, 8'h22);
                send_a(8'hA5, 8'h5A);
                send_a(8'hF0, 8'h0F);
                send_a(8'h7F, 8'h81);
            end
            begin
                for (int i = 0; i < 50 && !out_valid_a; i++) begin
                    @(posedge clk); #1;
                end
                check("a_bp_first_valid", out_valid_a, 1);
                out_ready_a = 1'b0;
                held = out_result_a;
                repeat (3) begin
                    @(negedge clk);
                    check("a_stall_valid", out_valid_a, 1);
                    check("a_stall_hold", out_result_a, held);
                    check("a_stall_in_ready", in_ready_a, 0);
                    @(posedge clk); #1;
                end
                out_ready_a = 1'b1;
            end
        join
        drain_a();

        // reset mid-flight: in-flight entries must vanish
        out_ready_a = 1'b0;
        send_a(8'h33, 8'h44);
        send_a(8'h55, 8'h66);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        exp_a.delete();
        @(negedge clk);
        check("a_midrst_out_valid", out_valid_a, 0);
        check("a_midrst_busy", busy_a, 0);
        check("a_midrst_out_result", out_result_a, 0);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        repeat (6) begin @(posedge clk); #1; end

        // random traffic
        begin
            int acc = 0;
            int cyc = 0;
            while (acc < 10000 && cyc < 40000) begin
                in_valid_a  = ($urandom_range(0, 3) != 0);
                in_sum_a    = WA'($urandom);
                in_carry_a  = WA'($urandom);
                out_ready_a = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_valid_a && in_ready_a) begin
                    exp_a.push_back(model(longint'(in_sum_a), longint'(in_carry_a)));
                    acc++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            check("a_rand_accepted", acc, 10000);
        end
        drain_a();
    endtask

    task automatic run_b();
        int acc = 0;
        int cyc = 0;
        int n = 0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_sum_b = '0; in_carry_b = '0; out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_out_valid", out_valid_b, 0);
        check("b_rst_busy", busy_b, 0);
        @(posedge clk); #1;

        while (acc < 10000 && cyc < 40000) begin
            in_valid_b  = ($urandom_range(0, 3) != 0);
            // bias some operands to all-ones to hit the top of the range
            in_sum_b    = ($urandom_range(0, 15) == 0) ? '1 : WB'($urandom);
            in_carry_b  = ($urandom_range(0, 15) == 0) ? '1 : WB'($urandom);
            out_ready_b = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid_b && in_ready_b) begin
                exp_b.push_back(model(longint'(in_sum_b), longint'(in_carry_b)));
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("b_rand_accepted", acc, 10000);

        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        while (exp_b.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("b_drain_left", exp_b.size(), 0);
        @(negedge clk);
        check("b_drain_busy", busy_b, 0);
    endtask

    initial begin
        rst_a = 1'b1; in_valid_a = 1'b0; in_sum_a = '0; in_carry_a = '0; out_ready_a = 1'b1;
        rst_b = 1'b1; in_valid_b = 1'b0; in_sum_b = '0; in_carry_b = '0; out_ready_b = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
